button_debouncer: RTL and testbench



---
 rtl/button_debouncer_pkg.sv | 15 +
 rtl/debounce_channel.sv | 78 +++++++
 rtl/button_debouncer.sv | 39 +++
 tb/tb_button_debouncer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// button_debouncer_pkg: shared hold-FSM encoding, counter width helper and 50 MHz timing defaults
package button_debouncer_pkg;
  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } btn_state_t;
  localparam int CLK_HZ              = 50_000_000;
  localparam int DEF_NUM_BTN         = 4;
  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;
  localparam int DEF_HOLD_CYCLES     = CLK_HZ;
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchroniser, debounce counter, hold FSM and event pulses for one button
//   clk, reset_n  clock and asynchronous active-low reset
//   i_btn         raw button pin, asynchronous to clk
//   o_level       debounced level, 1 = pressed
//   o_press       one-cycle pulse in the first cycle o_level reads 1
//   o_release     one-cycle pulse in the first cycle o_level reads 0
//   o_long        one-cycle pulse once a press has lasted HOLD_CYCLES
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);
  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic IDLE_PIN = ACTIVE_LOW != 0;
  logic          r_sync1;
  logic          r_sync2;
  logic [DW-1:0] r_db_cnt;
  logic [HW-1:0] r_hold_cnt;
  btn_state_t    r_state;
  logic          r_level;
  logic          r_press;
  logic          r_release;
  logic          r_long;
  logic          w_sample;
  logic          w_accept;
  logic          w_rise;
  logic          w_fall;
  assign w_sample = r_sync2 ^ IDLE_PIN;
  // the new level is taken on the edge where the counter already shows DEBOUNCE_CYCLES-1
  assign w_accept = (w_sample != r_level) && (r_db_cnt == DB_LAST);
  assign w_rise   = w_accept & w_sample;
  assign w_fall   = w_accept & ~w_sample;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= IDLE_PIN;
      r_sync2    <= IDLE_PIN;
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_state    <= RELEASED;
      r_level    <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_long     <= 1'b0;
    end else begin
      r_sync1    <= i_btn;
      r_sync2    <= r_sync1;
      r_db_cnt   <= (w_sample == r_level || w_accept) ? '0 : r_db_cnt + 1'b1;
      r_level    <= w_accept ? w_sample : r_level;
      r_press    <= w_rise;
      r_release  <= w_fall;
      // a fall landing on the hold threshold suppresses long_press
      r_long     <= (r_state == PRESSED) && (r_hold_cnt == HOLD_LAST) && !w_fall;
      r_hold_cnt <= (r_state == RELEASED) ? '0 :
                    (r_hold_cnt == HOLD_LAST) ? r_hold_cnt : r_hold_cnt + 1'b1;
      r_state    <= w_fall ? RELEASED :
                    w_rise ? PRESSED :
                    (r_state == HELD || (r_state == PRESSED && r_hold_cnt == HOLD_LAST)) ? HELD :
                    (r_state == PRESSED) ? PRESSED : RELEASED;
    end
  end
  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: per-channel synchronise, debounce and press/release/long-press detection
//   clk, reset_n   clock and asynchronous active-low reset
//   btn_in         raw button pins, asynchronous to clk
//   btn_level      debounced levels, 1 = pressed, feeds the PIO in_port
//   press_pulse    one-cycle pulse per channel when btn_level rises
//   release_pulse  one-cycle pulse per channel when btn_level falls
//   long_press     one-cycle pulse per channel after HOLD_CYCLES of press
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int NUM_BTN         = DEF_NUM_BTN,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_press
);
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(
      .ACTIVE_LOW     (ACTIVE_LOW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_btn    (btn_in[i]),
      .o_level  (btn_level[i]),
      .o_press  (press_pulse[i]),
      .o_release(release_pulse[i]),
      .o_long   (long_press[i])
    );
  end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: table, hand-written corner sequences and random stimulus against a reference model
module tb_button_debouncer;
  localparam int N = 4;
  localparam int DB = 4;
  localparam int HOLD = 20;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] btn_in = '1;
  logic [N-1:0] btn_level, press_pulse, release_pulse, long_press;
  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0] hist[$];
  logic [N-1:0] m_level, m_press, m_rel, m_long;
  int m_run[N];
  int m_age[N];
  logic [N-1:0] seen_p, seen_r, seen_l;
  typedef struct {
    logic [N-1:0] pins;
    int           cycles;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
  } vec_t;
  vec_t tbl[10];

  button_debouncer #(
    .NUM_BTN(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_in(btn_in), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_press(long_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference: the level seen two edges late flips once it has disagreed for DB edges in a row;
  // a press that has aged HOLD edges fires long unless it has already been released
  task automatic model_reset();
    hist.delete();
    hist.push_back('1);
    hist.push_back('1);
    m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
    for (int c = 0; c < N; c++) begin
      m_run[c] = 0;
      m_age[c] = 0;
    end
  endtask

  task automatic model_step();
    logic [N-1:0] s;
    s = hist.pop_front();
    hist.push_back(btn_in);
    m_press = '0; m_rel = '0; m_long = '0;
    for (int c = 0; c < N; c++) begin
      if (!s[c] != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] == DB) begin
          m_run[c] = 0;
          m_level[c] = !s[c];
          if (m_level[c]) m_press[c] = 1'b1;
          else m_rel[c] = 1'b1;
        end
      end else m_run[c] = 0;
      if (m_press[c]) m_age[c] = 0;
      else if (m_level[c]) begin
        m_age[c]++;
        if (m_age[c] == HOLD) m_long[c] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
    chk("level", btn_level, m_level);
    chk("press", press_pulse, m_press);
    chk("release", release_pulse, m_rel);
    chk("long", long_press, m_long);
    seen_p |= press_pulse;
    seen_r |= release_pulse;
    seen_l |= long_press;
  endtask

  function automatic logic [N-1:0] evt(input int kind);
    return kind == 0 ? press_pulse : kind == 1 ? release_pulse : long_press;
  endfunction

  task automatic wait_evt(input int kind, input logic [N-1:0] mask, input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim && n < 0; i++) begin
      tick();
      if ((evt(kind) & mask) != '0) n = i;
    end
  endtask

  task automatic do_reset(input logic [N-1:0] pins);
    #2 reset_n = 1'b0;
    btn_in = pins;
    #1 chk("async_reset", {btn_level, press_pulse, release_pulse, long_press}, 0);
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{4'hF, 10, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1] = '{4'hE, 10, 4'h1, 4'h1, 4'h0, 4'h0};
    tbl[2] = '{4'hE, 25, 4'h1, 4'h0, 4'h0, 4'h1};
    tbl[3] = '{4'hF, 10, 4'h0, 4'h0, 4'h1, 4'h0};
    tbl[4] = '{4'h3, 3,  4'h0, 4'h0, 4'h0, 4'h0};
    tbl[5] = '{4'hF, 10, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[6] = '{4'h7, 4,  4'h0, 4'h0, 4'h0, 4'h0};
    tbl[7] = '{4'hF, 12, 4'h0, 4'h8, 4'h8, 4'h0};
    tbl[8] = '{4'h0, 8,  4'hF, 4'hF, 4'h0, 4'h0};
    tbl[9] = '{4'hF, 8,  4'h0, 4'h0, 4'hF, 4'h0};
    seen_p = '0; seen_r = '0; seen_l = '0;
    model_reset();
    repeat (3) tick();
    chk("reset_outputs", {btn_level, press_pulse, release_pulse, long_press}, 0);
    reset_n = 1'b1;
    seen_p = '0; seen_r = '0; seen_l = '0;
    repeat (100) tick();
    chk("idle_level", btn_level, 0);
    chk("idle_pulses", {seen_p, seen_r, seen_l}, 0);
    btn_in = 4'hE;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("clean_level_e%0d", k), btn_level[0], k >= 5);
      chk($sformatf("clean_press_e%0d", k), press_pulse[0], k == 5);
    end
    chk("clean_others", btn_level[3:1], 0);
    btn_in = 4'hF;
    wait_evt(1, 4'h1, 10, n);
    chk("clean_release_lat", n, 6);
    repeat (5) tick();
    seen_p = '0;
    for (int i = 0; i < 30; i++) begin
      btn_in = 4'hF;
      btn_in[1] = ((i >> 1) & 1) == 0;
      tick();
    end
    chk("bounce_no_press", seen_p, 0);
    btn_in[1] = 1'b0;
    wait_evt(0, 4'h2, 10, n);
    chk("bounce_press_lat", n, 6);
    seen_p = '0;
    repeat (10) tick();
    chk("bounce_single_press", seen_p, 0);
    btn_in = 4'hF;
    wait_evt(1, 4'h2, 10, n);
    chk("bounce_release_lat", n, 6);
    repeat (5) tick();
    btn_in = 4'hB;
    wait_evt(0, 4'h4, 10, n);
    chk("long_press_lat", n, 6);
    wait_evt(2, 4'h4, 30, n);
    chk("long_hold_lat", n, 20);
    chk("long_only_bit2", long_press, 4'h4);
    seen_l = '0;
    repeat (30) tick();
    chk("long_no_repeat", seen_l, 0);
    btn_in = 4'hF;
    wait_evt(1, 4'h4, 10, n);
    chk("long_release_lat", n, 6);
    chk("long_none_after_release", seen_l, 0);
    repeat (5) tick();
    btn_in = 4'h6;
    wait_evt(0, 4'h9, 10, n);
    chk("simul_press_lat", n, 6);
    chk("simul_press", press_pulse, 4'h9);
    repeat (4) tick();
    seen_l = '0;
    btn_in = 4'hF;
    wait_evt(1, 4'h9, 10, n);
    chk("simul_release_lat", n, 6);
    chk("simul_release", release_pulse, 4'h9);
    chk("simul_no_long", seen_l, 0);
    repeat (5) tick();
    for (int k = 0; k < 2; k++) begin
      btn_in = 4'hD;
      wait_evt(0, 4'h2, 10, n);
      chk($sformatf("edge%0d_press_lat", k), n, 6);
      repeat (14 + k) tick();
      seen_l = '0;
      btn_in = 4'hF;
      wait_evt(1, 4'h2, 10, n);
      chk($sformatf("edge%0d_release_lat", k), n, 6);
      repeat (5) tick();
      chk($sformatf("edge%0d_long", k), seen_l[1], k);
    end
    btn_in = 4'hE;
    wait_evt(0, 4'h1, 10, n);
    chk("midhold_press_lat", n, 6);
    repeat (5) tick();
    do_reset(4'hE);
    wait_evt(0, 4'h1, 10, n);
    chk("midhold_repress_lat", n, 6);
    do_reset(4'hF);
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      seen_p = '0; seen_r = '0; seen_l = '0;
      btn_in = tbl[i].pins;
      repeat (tbl[i].cycles) tick();
      chk($sformatf("row%0d_level", i), btn_level, tbl[i].lvl);
      chk($sformatf("row%0d_press", i), seen_p, tbl[i].prs);
      chk($sformatf("row%0d_release", i), seen_r, tbl[i].rel);
      chk($sformatf("row%0d_long", i), seen_l, tbl[i].lng);
    end
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 39) == 0) do_reset(N'($urandom));
      btn_in = N'($urandom);
      repeat (($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 8)) tick();
    end
    btn_in = '1;
    repeat (10) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
